// File: rtl/stream_phase_profiler_pkg.sv
// Shared types and constants for the stream phase profiler.
package stream_profiler_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    GAP   = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [16:0] DEFAULT_DONE_TOKEN = 17'h10100;

endpackage

// File: rtl/stream_phase_profiler_if.sv
// Bundle of the observed write streams and read-side trigger/done flags.
interface stream_phase_profiler_if #(
  parameter int DATA_WIDTH = 17,
  parameter int NUM_WR     = 1,
  parameter int NUM_RD     = 1
);
  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data;
  logic [NUM_WR-1:0]                 wr_valid;
  logic [NUM_WR-1:0]                 wr_ready;
  logic                              rd_start_valid;
  logic [NUM_RD-1:0]                 rd_done;

  modport master (output wr_data, wr_valid, wr_ready, rd_start_valid, rd_done);
  modport slave  (input  wr_data, wr_valid, wr_ready, rd_start_valid, rd_done);
endinterface

// File: rtl/stream_phase_profiler_sat_counter.sv
// Up-counter that loads, increments and sticks at all-ones; sat flags a lost increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  assign sat = inc && !load && (count == '1);

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stream_phase_profiler.sv
// Passive profiler timing the write phase, inter-phase gap and read phase of a buffer.
module stream_phase_profiler
  import stream_profiler_pkg::*;
#(
  parameter int DATA_WIDTH = 17,
  parameter int NUM_WR     = 1,
  parameter int NUM_RD     = 1,
  parameter int CNT_WIDTH  = 32,
  parameter int GAP_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  flush,
  stream_phase_profiler_if.slave obs,
  input  logic [DATA_WIDTH-1:0] cfg_done_token,
  input  logic [GAP_WIDTH-1:0]  cfg_wait_gap,
  output logic [2:0]            state,
  output logic [CNT_WIDTH-1:0]  write_cycles,
  output logic [CNT_WIDTH-1:0]  read_cycles,
  output logic                  write_done,
  output logic                  read_done,
  output logic                  cnt_sat
);

  state_e                cur;
  logic [NUM_WR-1:0]     eos_q;
  logic [NUM_WR-1:0]     hs_done;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic                  eos_all, rd_all, gap_zero;
  logic                  wr_load, wr_inc, wr_sat;
  logic                  rd_load, rd_inc, rd_sat;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hs_done = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      hs_done[i] = obs.wr_valid[i] && obs.wr_ready[i] && (obs.wr_data[i] == cfg_done_token);
    end
  end

  // A channel finishing this cycle counts toward closing the write phase now.
  assign eos_all  = &(eos_q | hs_done);
  assign rd_all   = &obs.rd_done;
  assign gap_zero = (gap_cnt == '0);

  assign wr_load = clk_en && (cur == IDLE) && (|obs.wr_valid);
  assign wr_inc  = clk_en && (cur == WRITE);
  assign rd_load = clk_en && (cur == GAP) && gap_zero && obs.rd_start_valid;
  assign rd_inc  = clk_en && (cur == READ) && !rd_all;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_write_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .load     (wr_load),
    .load_val (CNT_WIDTH'(1)),
    .inc      (wr_inc),
    .count    (write_cycles),
    .sat      (wr_sat)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_read_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .load     (rd_load),
    .load_val (CNT_WIDTH'(1)),
    .inc      (rd_inc),
    .count    (read_cycles),
    .sat      (rd_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cur        <= IDLE;
      eos_q      <= '0;
      gap_cnt    <= '0;
      write_done <= 1'b0;
      read_done  <= 1'b0;
      cnt_sat    <= 1'b0;
    end else if (clk_en) begin
      cnt_sat <= cnt_sat | wr_sat | rd_sat;
      case (cur)
        IDLE: begin
          eos_q <= hs_done;
          if (|obs.wr_valid) cur <= WRITE;
        end
        WRITE: begin
          eos_q <= eos_q | hs_done;
          if (eos_all) begin
            cur        <= GAP;
            write_done <= 1'b1;
            gap_cnt    <= cfg_wait_gap;
          end
        end
        GAP: begin
          // A trigger arriving before the gap has run out is deliberately dropped.
          if (!gap_zero)                gap_cnt <= gap_cnt - 1'b1;
          else if (obs.rd_start_valid) cur     <= READ;
        end
        READ: begin
          if (rd_all) begin
            cur       <= DONE;
            read_done <= 1'b1;
          end
        end
        DONE:    cur <= DONE;
        default: cur <= IDLE;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_stream_phase_profiler.sv
// Bench: directed vector table, hand sequences, and random traffic against a timestamp model.
module tb_stream_phase_profiler;
  import stream_profiler_pkg::*;

  localparam int DW = 17;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          rst_n, clk_en, flush;
  logic [DW-1:0] tok;
  logic [GW-1:0] gap;
  int            checks = 0;
  int            errors = 0;
  bit            chk_on = 1'b0;

  always #5 clk = ~clk;

  stream_phase_profiler_if #(.DATA_WIDTH(DW), .NUM_WR(1), .NUM_RD(1)) bus1 ();
  stream_phase_profiler_if #(.DATA_WIDTH(DW), .NUM_WR(2), .NUM_RD(2)) bus2 ();

  logic [2:0]  st1, st2, st3;
  logic [31:0] wc1, rc1, wc2, rc2;
  logic [3:0]  wc3, rc3;
  logic        wd1, rd1, sat1, wd2, rd2, sat2, wd3, rd3, sat3;

  stream_phase_profiler #(.DATA_WIDTH(DW), .NUM_WR(1), .NUM_RD(1), .CNT_WIDTH(32), .GAP_WIDTH(GW)) u1 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .obs(bus1.slave),
    .cfg_done_token(tok), .cfg_wait_gap(gap), .state(st1), .write_cycles(wc1),
    .read_cycles(rc1), .write_done(wd1), .read_done(rd1), .cnt_sat(sat1));

  stream_phase_profiler #(.DATA_WIDTH(DW), .NUM_WR(2), .NUM_RD(2), .CNT_WIDTH(32), .GAP_WIDTH(GW)) u2 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .obs(bus2.slave),
    .cfg_done_token(tok), .cfg_wait_gap(gap), .state(st2), .write_cycles(wc2),
    .read_cycles(rc2), .write_done(wd2), .read_done(rd2), .cnt_sat(sat2));

  stream_phase_profiler #(.DATA_WIDTH(DW), .NUM_WR(1), .NUM_RD(1), .CNT_WIDTH(4), .GAP_WIDTH(GW)) u3 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .obs(bus1.slave),
    .cfg_done_token(tok), .cfg_wait_gap(gap), .state(st3), .write_cycles(wc3),
    .read_cycles(rc3), .write_done(wd3), .read_done(rd3), .cnt_sat(sat3));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: phases are remembered as tick timestamps; counts are differences.
  typedef struct {
    state_e     ph;
    int         tick, w_start, w_end, r_start, r_end, g_entry, g_len;
    logic [1:0] eos;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.ph = IDLE; m.tick = 0; m.w_start = 0; m.w_end = -1; m.r_start = 0; m.r_end = -1;
    m.g_entry = 0; m.g_len = 0; m.eos = '0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, logic [1:0] v, logic [1:0] r, logic [1:0][DW-1:0] d,
                                    int nwr, logic rsv, logic alldone, logic [DW-1:0] t, int g);
    mdl_t       n = m;
    logic [1:0] mask = (nwr == 2) ? 2'b11 : 2'b01;
    logic [1:0] fin = '0;
    for (int i = 0; i < nwr; i++) fin[i] = v[i] && r[i] && (d[i] == t);
    n.tick = m.tick + 1;
    case (m.ph)
      IDLE:  if ((v & mask) != 0) begin n.ph = WRITE; n.w_start = n.tick; n.eos = fin; end
      WRITE: begin
        n.eos = m.eos | fin;
        if ((n.eos & mask) == mask) begin
          n.ph = GAP; n.w_end = n.tick; n.g_entry = n.tick + 1; n.g_len = g;
        end
      end
      GAP:   if ((n.tick - m.g_entry >= m.g_len) && rsv) begin n.ph = READ; n.r_start = n.tick; end
      READ:  if (alldone) begin n.ph = DONE; n.r_end = n.tick; end
      default: ;
    endcase
    return n;
  endfunction

  function automatic longint wraw(mdl_t m);
    if (m.ph == IDLE) return 0;
    if (m.w_end >= 0) return longint'(m.w_end - m.w_start + 1);
    return longint'(m.tick - m.w_start + 1);
  endfunction

  function automatic longint rraw(mdl_t m);
    if (m.ph == READ) return longint'(m.tick - m.r_start + 1);
    if (m.ph == DONE) return longint'(m.r_end - m.r_start);
    return 0;
  endfunction

  task automatic check_dut(input string tag, input mdl_t m, input int cw, input logic [2:0] st,
                           input logic [63:0] wc, input logic [63:0] rc, input logic wd,
                           input logic rdn, input logic sat);
    longint mx = (longint'(1) << cw) - 1;
    longint wr = wraw(m);
    longint rr = rraw(m);
    check({tag, ".state"},        64'(st),  64'(m.ph));
    check({tag, ".write_cycles"}, wc,       (wr > mx) ? mx : wr);
    check({tag, ".read_cycles"},  rc,       (rr > mx) ? mx : rr);
    check({tag, ".write_done"},   64'(wd),  64'(m.ph inside {GAP, READ, DONE}));
    check({tag, ".read_done"},    64'(rdn), 64'(m.ph == DONE));
    check({tag, ".cnt_sat"},      64'(sat), 64'((wr > mx) || (rr > mx)));
  endtask

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      m1 = mdl_reset();
      m2 = mdl_reset();
    end else if (clk_en) begin
      m1 = mdl_step(m1, {1'b0, bus1.wr_valid}, {1'b0, bus1.wr_ready}, {17'd0, bus1.wr_data[0]}, 1,
                    bus1.rd_start_valid, &bus1.rd_done, tok, int'(gap));
      m2 = mdl_step(m2, bus2.wr_valid, bus2.wr_ready, bus2.wr_data, 2,
                    bus2.rd_start_valid, &bus2.rd_done, tok, int'(gap));
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check_dut("u1", m1, 32, st1, 64'(wc1), 64'(rc1), wd1, rd1, sat1);
      check_dut("u3", m1, 4,  st3, 64'(wc3), 64'(rc3), wd3, rd3, sat3);
      check_dut("u2", m2, 32, st2, 64'(wc2), 64'(rc2), wd2, rd2, sat2);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_all();
    bus1.wr_data = '0; bus1.wr_valid = '0; bus1.wr_ready = '0; bus1.rd_start_valid = 1'b0; bus1.rd_done = '0;
    bus2.wr_data = '0; bus2.wr_valid = '0; bus2.wr_ready = '0; bus2.rd_start_valid = 1'b0; bus2.rd_done = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  typedef struct {
    int lead, ntok, gap, rd_wait;
    int exp_wc, exp_rc, exp_lat, exp_wc4, exp_rc4;
    bit exp_sat4;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat;

    vecs[0] = '{lead: 3, ntok: 9,  gap: 0, rd_wait: 8,  exp_wc: 9,  exp_rc: 8,  exp_lat: 1, exp_wc4: 9,  exp_rc4: 8,  exp_sat4: 0};
    vecs[1] = '{lead: 0, ntok: 2,  gap: 0, rd_wait: 1,  exp_wc: 2,  exp_rc: 1,  exp_lat: 1, exp_wc4: 2,  exp_rc4: 1,  exp_sat4: 0};
    vecs[2] = '{lead: 2, ntok: 20, gap: 4, rd_wait: 3,  exp_wc: 20, exp_rc: 3,  exp_lat: 5, exp_wc4: 15, exp_rc4: 3,  exp_sat4: 1};
    vecs[3] = '{lead: 1, ntok: 4,  gap: 2, rd_wait: 17, exp_wc: 4,  exp_rc: 17, exp_lat: 3, exp_wc4: 4,  exp_rc4: 15, exp_sat4: 1};

    rst_n = 1'b0; flush = 1'b0; clk_en = 1'b1; tok = DEFAULT_DONE_TOKEN; gap = '0;
    idle_all();
    repeat (2) tick();
    check("reset.state",   64'(st1),  64'(IDLE));
    check("reset.wc",      64'(wc1),  64'd0);
    check("reset.rc",      64'(rc2),  64'd0);
    check("reset.sat",     64'(sat3), 64'd0);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    foreach (vecs[v]) begin
      gap = GW'(vecs[v].gap);
      do_flush();
      repeat (vecs[v].lead) tick();
      for (int k = 0; k < vecs[v].ntok; k++) begin
        bus1.wr_valid = 1'b1; bus1.wr_ready = 1'b1;
        bus1.wr_data[0] = (k == vecs[v].ntok - 1) ? tok : DW'(k + 1);
        tick();
      end
      bus1.wr_valid = 1'b0; bus1.wr_ready = 1'b0;
      bus1.rd_start_valid = 1'b1;
      bus1.rd_done = (vecs[v].rd_wait == 1);
      check($sformatf("vec%0d.gap_entry", v), 64'(st1), 64'(GAP));
      check($sformatf("vec%0d.wc", v),  64'(wc1), 64'(vecs[v].exp_wc));
      check($sformatf("vec%0d.wc4", v), 64'(wc3), 64'(vecs[v].exp_wc4));
      lat = 0;
      while (st1 != READ && lat < 50) begin
        tick();
        lat++;
      end
      check($sformatf("vec%0d.gap_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
      bus1.rd_done = 1'b0;
      repeat (vecs[v].rd_wait - 1) tick();
      bus1.rd_done = 1'b1;
      tick();
      bus1.rd_start_valid = 1'b0;
      check($sformatf("vec%0d.done", v), 64'(st1),  64'(DONE));
      check($sformatf("vec%0d.rc", v),   64'(rc1),  64'(vecs[v].exp_rc));
      check($sformatf("vec%0d.rc4", v),  64'(rc3),  64'(vecs[v].exp_rc4));
      check($sformatf("vec%0d.sat4", v), 64'(sat3), 64'(vecs[v].exp_sat4));
      tick(); tick();
      check($sformatf("vec%0d.hold", v), 64'(st1), 64'(DONE));
      idle_all();
    end

    // Two channels, staggered finish; ch0 ready wanders before its done token.
    gap = '0;
    do_flush();
    for (int c = 0; c <= 14; c++) begin
      bus2.wr_valid   = {1'b1, (c <= 5)};
      bus2.wr_ready   = {1'b1, (c == 5) ? 1'b1 : 1'($urandom_range(1))};
      bus2.wr_data[0] = (c == 5)  ? tok : DW'(c + 1);
      bus2.wr_data[1] = (c == 14) ? tok : DW'(c + 1);
      if (c == 14) check("stagger.before", 64'(st2), 64'(WRITE));
      tick();
    end
    check("stagger.gap",   64'(st2), 64'(GAP));
    check("stagger.wc",    64'(wc2), 64'd15);
    check("stagger.wdone", 64'(wd2), 64'd1);
    idle_all();

    // Done token offered with ready low: only the real handshake closes the phase.
    do_flush();
    bus1.wr_valid = 1'b1; bus1.wr_ready = 1'b1; bus1.wr_data[0] = DW'(1);
    tick();
    bus1.wr_data[0] = tok; bus1.wr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("noready.%0d", c), 64'(st1), 64'(WRITE));
    end
    bus1.wr_ready = 1'b1;
    tick();
    check("noready.gap", 64'(st1), 64'(GAP));
    check("noready.wc",  64'(wc1), 64'd5);
    idle_all();

    // clk_en low mid-write freezes everything, even a done-token handshake; then flush in READ.
    do_flush();
    bus1.wr_valid = 1'b1; bus1.wr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus1.wr_data[0] = DW'(k + 1);
      tick();
    end
    clk_en = 1'b0; bus1.wr_data[0] = tok;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("frozen.wc%0d", c), 64'(wc1), 64'd3);
      check($sformatf("frozen.st%0d", c), 64'(st1), 64'(WRITE));
    end
    clk_en = 1'b1; bus1.wr_data[0] = DW'(5);
    tick();
    bus1.wr_data[0] = tok;
    tick();
    check("frozen.gap", 64'(st1), 64'(GAP));
    check("frozen.wc",  64'(wc1), 64'd5);
    bus1.wr_valid = 1'b0; bus1.rd_start_valid = 1'b1;
    tick(); tick();
    check("flush.pre_rc", 64'(rc1), 64'd2);
    do_flush();
    tick();
    check("flush.state", 64'(st1),  64'(IDLE));
    check("flush.wc",    64'(wc1),  64'd0);
    check("flush.rc",    64'(rc1),  64'd0);
    check("flush.wd",    64'(wd1),  64'd0);
    check("flush.rd",    64'(rd1),  64'd0);
    check("flush.sat3",  64'(sat3), 64'd0);
    idle_all();

    // Random traffic on both buses, scored cycle by cycle against the model.
    for (int c = 0; c < 2500; c++) begin
      flush  = ($urandom_range(59) == 0);
      clk_en = ($urandom_range(9) != 0);
      rst_n  = (c != 1200);
      gap    = GW'($urandom_range(3));
      bus1.wr_valid       = 1'($urandom_range(9) < 7);
      bus1.wr_ready       = 1'($urandom_range(1));
      bus1.wr_data[0]     = ($urandom_range(4) == 0) ? tok : DW'($urandom);
      bus1.rd_start_valid = 1'($urandom_range(1));
      bus1.rd_done        = 1'($urandom_range(9) < 6);
      for (int i = 0; i < 2; i++) begin
        bus2.wr_valid[i] = 1'($urandom_range(9) < 7);
        bus2.wr_ready[i] = 1'($urandom_range(1));
        bus2.wr_data[i]  = ($urandom_range(4) == 0) ? tok : DW'($urandom);
        bus2.rd_done[i]  = 1'($urandom_range(9) < 7);
      end
      bus2.rd_start_valid = 1'($urandom_range(1));
      tick();
    end
    rst_n = 1'b1; flush = 1'b0; clk_en = 1'b1;
    idle_all();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_phase_profiler.md
# stream_phase_profiler

Synthesizable, parametrised cycle profiler for sparse-tile unit benches and on-chip debug taps. It passively observes N write-side ready/valid streams and M read-side completion flags. It measures three intervals: the write phase (first valid to the final done-token handshake), a programmable inter-phase gap, and the read phase (read trigger to all-done). It sits beside a fiber_access / buffet instance and never drives any handshake.

## Interface
Parameters:
- DATA_WIDTH, 17, stream token width
- NUM_WR, 1, number of observed write streams
- NUM_RD, 1, number of read-side done flags
- CNT_WIDTH, 32, width of each cycle counter
- GAP_WIDTH, 16, width of the gap config and gap counter

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; synchronous, active-low
- clk_en  in  1  global clock enable; when low, all state holds
- flush  in  1  synchronous soft restart; same effect as reset
- wr_data  in  NUM_WR×DATA_WIDTH  observed write stream tokens
- wr_valid  in  NUM_WR  observed write valids
- wr_ready  in  NUM_WR  observed write readys
- rd_start_valid  in  1  read trigger (upstream pos stream valid)
- rd_done  in  NUM_RD  read consumer done flags
- cfg_done_token  in  DATA_WIDTH  done token value; typically 17'h10100
- cfg_wait_gap  in  GAP_WIDTH  number of gap cycles before the read is armed
- state  out  3  current FSM state
- write_cycles  out  CNT_WIDTH  write-phase length
- read_cycles  out  CNT_WIDTH  read-phase length
- write_done  out  1  write phase closed
- read_done  out  1  read phase closed
- cnt_sat  out  1  sticky flag; some counter saturated

## Operation
- States: IDLE, WRITE, GAP, READ, DONE.
- IDLE→WRITE on any wr_valid[i]. write_cycles←1 on that cycle.
- Per-channel eos flag: set on a handshake (valid & ready) where wr_data[i]==cfg_done_token. The flag is sticky until IDLE.
- WRITE: write_cycles increments every cycle.
- WRITE→GAP when all eos flags, including any set this cycle, are set. That cycle is counted. write_done←1. Gap counter←cfg_wait_gap.
- Multiple channels finishing in the same cycle: a single transition.
- GAP:
  - Counter ≠0: decrement.
  - Counter ==0 and rd_start_valid: go to READ, read_cycles←1.
  - rd_start_valid while counter ≠0 is ignored.
- READ: read_cycles increments while ~&rd_done.
- READ→DONE on the first cycle with &rd_done. That cycle is not counted. read_done←1.
- If &rd_done is already true at the trigger, READ lasts one cycle and read_cycles=1.
- DONE holds until rst_n low or flush.
- Counters saturate at all-ones and set cnt_sat. Counters never wrap.
- Config inputs are sampled every cycle. Changing a config mid-phase is the user's responsibility. cfg_wait_gap is sampled only on GAP entry.

## Timing
- Reset / flush: state=IDLE, counters=0, eos flags=0, write_done=read_done=cnt_sat=0.
- Reset and flush take priority over clk_en and over all transitions.
- Reset or flush mid-phase discards all measurements.
- All outputs are registered; there is no combinational input→output path.
- Counts are visible the cycle after the increment edge.
- clk_en=0: no state change, no counting, no eos capture. Handshakes in those cycles are ignored.

## Structure
- Package stream_profiler_pkg holds:
  - state enum (IDLE=0, WRITE=1, GAP=2, READ=3, DONE=4)
  - DEFAULT_DONE_TOKEN=17'h10100
- Sub-module sat_counter (parametrised width; ports: load, load_val, inc, sat). Instantiated for write_cycles and read_cycles.
- The gap counter is an inline down-counter.
- Target size: ~200 lines of RTL.

## Test plan
- NUM_WR=1, gap=0:
  - Stimulus: valid at cycle 3, 9 tokens, done token handshaken at cycle 11; rd_start_valid at cycle 12; rd_done at cycle 20.
  - Required: write_cycles=9, read_cycles=8, state=DONE.
- NUM_WR=2, staggered finish:
  - Stimulus: ch0 done token at cycle 5, ch1 at cycle 14; ch0 ready toggled at random.
  - Required: GAP entered at cycle 15, write_cycles counts through cycle 14.
- Gap=4:
  - Stimulus: rd_start_valid held high from GAP entry.
  - Required: READ entered exactly 5 cycles after GAP entry.
- Done token with ready low:
  - Stimulus: done token present for 3 cycles before ready rises.
  - Required: eos set only on the handshake cycle.
- clk_en low for 6 cycles mid-WRITE, then flush in READ:
  - Required: counts frozen during the clk_en-low cycles; after flush, all outputs are at reset values.
- CNT_WIDTH=4:
  - Stimulus: a 20-cycle write phase.
  - Required: write_cycles=15, cnt_sat=1.
